// File: rtl/demux_1x4_stream.sv
// rtl/demux_1x4_stream.sv - 1-to-4 stream demultiplexer with one holding register per channel
//
// Steers each accepted input word into one of four output channels. Each
// channel owns a single holding register (data + valid flag), so a channel
// can accept a new word in the same cycle it delivers the old one.
//
// Configuration macro: DEMUX_ROUND_ROBIN_EN
//   defined   - destination comes from an internal 2-bit round-robin pointer
//               that advances once per accepted word; s0/s1 are ignored.
//   undefined - destination is {s1,s0}.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst        - synchronous active-high reset
//   x_in       - input data word (bits wide)
//   in_valid   - x_in carries a word this cycle
//   in_ready   - the block accepts the word this cycle (combinational)
//   s0, s1     - destination select, LSB / MSB
//   y0..y3     - per-channel registered data
//   out_valid  - bit k set: y<k> holds an undelivered word
//   out_ready  - bit k set: channel k sink takes y<k> this cycle

module demux_1x4_stream #(
    parameter int bits = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [bits-1:0] x_in,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            s0,
    input  logic            s1,
    output logic [bits-1:0] y0,
    output logic [bits-1:0] y1,
    output logic [bits-1:0] y2,
    output logic [bits-1:0] y3,
    output logic [3:0]      out_valid,
    input  logic [3:0]      out_ready
);

    logic [bits-1:0] data_q [4];
    logic [bits-1:0] data_d [4];
    logic [3:0]      valid_q;
    logic [3:0]      valid_d;
    logic [1:0]      dst;
    logic            accept;

`ifdef DEMUX_ROUND_ROBIN_EN
    logic [1:0] ptr_q;
    logic [1:0] ptr_d;
    logic       unused_sel;

    // Select inputs stay on the port list but carry no meaning here.
    assign unused_sel = s0 ^ s1;
    assign dst        = ptr_q;
    assign ptr_d      = accept ? ptr_q + 2'd1 : ptr_q;
`else
    assign dst = {s1, s0};
`endif

    // A channel can take a word if it is empty or is being emptied this cycle.
    // Held low during reset so nothing presented then is consumed.
    assign in_ready = !rst && (!valid_q[dst] || out_ready[dst]);
    assign accept   = in_valid && in_ready;

    always_comb begin
        // Drain first, then let a load on the same channel override it so a
        // simultaneous deliver+accept keeps the channel valid without a bubble.
        valid_d = valid_q & ~out_ready;
        for (int k = 0; k < 4; k++) begin
            data_d[k] = data_q[k];
        end
        if (accept) begin
            valid_d[dst] = 1'b1;
            data_d[dst]  = x_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
            end
`ifdef DEMUX_ROUND_ROBIN_EN
            ptr_q <= 2'd0;
`endif
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= data_d[k];
            end
`ifdef DEMUX_ROUND_ROBIN_EN
            ptr_q <= ptr_d;
`endif
        end
    end

    assign y0        = data_q[0];
    assign y1        = data_q[1];
    assign y2        = data_q[2];
    assign y3        = data_q[3];
    assign out_valid = valid_q;

endmodule

// File: tb/tb_demux_1x4_stream.sv
// tb/tb_demux_1x4_stream.sv - self-checking bench for demux_1x4_stream
module tb_demux_1x4_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] x_in;
    logic        in_valid;
    logic        in_ready;
    logic        s0;
    logic        s1;
    logic [15:0] y0, y1, y2, y3;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    demux_1x4_stream #(.bits(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .x_in      (x_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s0        (s0),
        .s1        (s1),
        .y0        (y0),
        .y1        (y1),
        .y2        (y2),
        .y3        (y3),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [1:0]  dst;
        logic [15:0] x;
        logic [3:0]  ordy;
        logic        exp_rdy;
        logic [3:0]  exp_ov;
        int          ch;
        logic [15:0] exp_y;
    } vec_t;

    vec_t tbl [20];

    // Reference state: what each channel is holding, plus the round-robin pointer.
    logic [15:0] m_data [4];
    logic        m_full [4];
    int          m_ptr;

    function automatic logic [15:0] ysel(input int k);
        case (k)
            0:       return y0;
            1:       return y1;
            2:       return y2;
            default: return y3;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [1:0] d,
                         input logic [15:0] x, input logic [3:0] o);
        rst       = r;
        in_valid  = v;
        {s1, s0}  = d;
        x_in      = x;
        out_ready = o;
    endtask

    // One model cycle driven from the rules: returns expected in_ready and
    // updates the reference state as the clock edge would.
    task automatic model_cycle(input logic r, input logic v, input logic [1:0] sel,
                               input logic [15:0] x, input logic [3:0] o,
                               output logic rdy);
        int d;
`ifdef DEMUX_ROUND_ROBIN_EN
        d = m_ptr;
`else
        d = int'(sel);
`endif
        rdy = (r == 1'b0) && (!m_full[d] || o[d]);
        if (r) begin
            for (int k = 0; k < 4; k++) begin
                m_full[k] = 1'b0;
                m_data[k] = 16'h0000;
            end
            m_ptr = 0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (o[k]) m_full[k] = 1'b0;
            end
            if (v && rdy) begin
                m_full[d] = 1'b1;
                m_data[d] = x;
                m_ptr     = (m_ptr + 1) % 4;
            end
        end
    endtask

    initial begin
        logic       r, v, rdy;
        logic [1:0] sel;
        logic [15:0] x;
        logic [3:0] o, exp_ov;

        drive(1'b1, 1'b0, 2'd0, 16'h0, 4'h0);

        // {rst, vld, dst, x, out_ready, exp in_ready, exp out_valid, channel, exp y}
        tbl[0]  = '{1'b1, 1'b1, 2'd0, 16'hDEAD, 4'hF, 1'b0, 4'b0000, 0, 16'h0000};
        tbl[1]  = '{1'b0, 1'b1, 2'd0, 16'h1111, 4'hF, 1'b1, 4'b0001, 0, 16'h1111};
        tbl[2]  = '{1'b0, 1'b1, 2'd1, 16'h2222, 4'hF, 1'b1, 4'b0010, 1, 16'h2222};
        tbl[3]  = '{1'b0, 1'b1, 2'd2, 16'h3333, 4'hF, 1'b1, 4'b0100, 2, 16'h3333};
        tbl[4]  = '{1'b0, 1'b1, 2'd3, 16'h4444, 4'hF, 1'b1, 4'b1000, 3, 16'h4444};
        tbl[5]  = '{1'b0, 1'b0, 2'd0, 16'h0000, 4'hF, 1'b1, 4'b0000, 3, 16'h4444};
        tbl[6]  = '{1'b0, 1'b1, 2'd2, 16'hAAAA, 4'hB, 1'b1, 4'b0100, 2, 16'hAAAA};
        tbl[7]  = '{1'b0, 1'b1, 2'd2, 16'hBBBB, 4'hB, 1'b0, 4'b0100, 2, 16'hAAAA};
        tbl[8]  = '{1'b0, 1'b1, 2'd2, 16'hBBBB, 4'hF, 1'b1, 4'b0100, 2, 16'hBBBB};
        tbl[9]  = '{1'b0, 1'b0, 2'd2, 16'h0000, 4'hF, 1'b1, 4'b0000, 2, 16'hBBBB};
        tbl[10] = '{1'b0, 1'b1, 2'd0, 16'h0007, 4'hE, 1'b1, 4'b0001, 0, 16'h0007};
        tbl[11] = '{1'b0, 1'b1, 2'd3, 16'h0005, 4'hE, 1'b1, 4'b1001, 3, 16'h0005};
        tbl[12] = '{1'b0, 1'b1, 2'd3, 16'h0005, 4'hE, 1'b1, 4'b1001, 0, 16'h0007};
        tbl[13] = '{1'b0, 1'b1, 2'd3, 16'h0005, 4'hE, 1'b1, 4'b1001, 3, 16'h0005};
        tbl[14] = '{1'b0, 1'b1, 2'd0, 16'h0009, 4'hE, 1'b0, 4'b0001, 0, 16'h0007};
        tbl[15] = '{1'b0, 1'b1, 2'd1, 16'h0101, 4'h0, 1'b1, 4'b0011, 1, 16'h0101};
        tbl[16] = '{1'b0, 1'b1, 2'd3, 16'h0303, 4'h0, 1'b1, 4'b1011, 3, 16'h0303};
        tbl[17] = '{1'b1, 1'b1, 2'd2, 16'h0202, 4'h0, 1'b0, 4'b0000, 1, 16'h0000};
        tbl[18] = '{1'b0, 1'b0, 2'd3, 16'h0000, 4'h0, 1'b1, 4'b0000, 3, 16'h0000};
        tbl[19] = '{1'b0, 1'b1, 2'd2, 16'h0202, 4'h0, 1'b1, 4'b0100, 2, 16'h0202};

        @(negedge clk);
`ifndef DEMUX_ROUND_ROBIN_EN
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].rst, tbl[i].vld, tbl[i].dst, tbl[i].x, tbl[i].ordy);
            #1;
            chk($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(tbl[i].exp_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].exp_ov));
            chk($sformatf("row%0d y%0d", i, tbl[i].ch), 32'(ysel(tbl[i].ch)), 32'(tbl[i].exp_y));
            @(negedge clk);
        end
`else
        drive(1'b1, 1'b0, 2'd3, 16'h0, 4'hF);
        @(posedge clk);
        @(negedge clk);
        for (int i = 1; i <= 5; i++) begin
            drive(1'b0, 1'b1, 2'd3, 16'(i), 4'hF);
            #1;
            chk($sformatf("rr%0d in_ready", i), 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
            chk($sformatf("rr%0d out_valid", i), 32'(out_valid), 32'(4'b0001 << ((i - 1) % 4)));
            chk($sformatf("rr%0d y", i), 32'(ysel((i - 1) % 4)), 32'(i));
            @(negedge clk);
        end
`endif

        // Randomized traffic against the reference model, starting from reset.
        for (int c = 0; c < 400; c++) begin
            r   = (c == 0) || ($urandom_range(0, 40) == 0);
            v   = ($urandom_range(0, 3) != 0);
            sel = 2'($urandom_range(0, 3));
            x   = 16'($urandom);
            o   = 4'($urandom);
            drive(r, v, sel, x, o);
            model_cycle(r, v, sel, x, o, rdy);
            #1;
            chk($sformatf("rnd%0d in_ready", c), 32'(in_ready), 32'(rdy));
            @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++) exp_ov[k] = m_full[k];
            chk($sformatf("rnd%0d out_valid", c), 32'(out_valid), 32'(exp_ov));
            for (int k = 0; k < 4; k++) begin
                if (m_full[k] || r) begin
                    chk($sformatf("rnd%0d y%0d", c, k), 32'(ysel(k)), 32'(m_data[k]));
                end
            end
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_1x4_stream.md
DEMUX_1X4_STREAM -- requirements
Module: demux_1x4_stream

Interface
REQ-001 Parameter: bits, default 16, data width of the input word and of each output channel.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 x_in  input  bits  input data word.
REQ-005 in_valid  input  1  x_in carries a word this cycle.
REQ-006 in_ready  output  1  the block accepts the word this cycle.
REQ-007 s0  input  1  destination select, LSB.
REQ-008 s1  input  1  destination select, MSB.
REQ-009 y0, y1, y2, y3  output  bits each  per-channel registered data.
REQ-010 out_valid  output  4  bit k set: y<k> holds an undelivered word.
REQ-011 out_ready  input  4  bit k set: the channel k sink takes y<k> this cycle.

Function
REQ-012 Destination dst (2 bits) SHALL be {s1,s0}, sampled in the same cycle as in_valid; the round-robin pointer replaces it when the macro in REQ-025 is defined.
REQ-013 Each channel SHALL have one holding register (data plus valid flag); there is no other buffering.
REQ-014 in_ready SHALL be combinational: 1 when out_valid[dst]=0 or out_ready[dst]=1, else 0; it does not depend on in_valid.
REQ-015 Accept: in_valid=1 and in_ready=1; on the next edge y<dst> takes x_in and out_valid[dst] goes to 1; latency is 1 cycle.
REQ-016 Deliver: out_valid[k]=1 and out_ready[k]=1; on the next edge out_valid[k] goes to 0 unless the same edge also loads channel k.
REQ-017 Simultaneous deliver and accept on the same channel: out_valid stays 1, y<k> updates to the new word, and no bubble appears.
REQ-018 Non-selected channels SHALL drain independently and in parallel with the input transfer.
REQ-019 y<k> SHALL hold its last value after delivery; its data is meaningful only while out_valid[k]=1.
REQ-020 in_valid=1 with in_ready=0 (selected channel full and stalled): no state change, and the word is held by the source (no drop).
REQ-021 Changing s0/s1 while stalled SHALL retarget immediately; in_ready is re-evaluated against the new dst in the same cycle.

Reset
REQ-022 When rst=1 at a clock edge, out_valid SHALL be 4'b0000, y0 to y3 SHALL be all zeros, and the round-robin pointer SHALL be 0, regardless of any transfer in the same cycle.
REQ-023 in_ready during reset SHALL be 0; any word presented while rst=1 is not accepted.
REQ-024 Reset asserted mid-stream SHALL discard all buffered words; the first accept after reset goes to the channel given by REQ-012 with the pointer at 0.

Configuration
REQ-025 Macro DEMUX_ROUND_ROBIN_EN SHALL select the destination source as follows.
- Defined: dst comes from an internal 2-bit pointer; s0/s1 are ignored; the pointer increments by 1 per accept and wraps 3 to 0; it is not advanced by stalls or drains.
- Undefined: dst={s1,s0}; the pointer logic is absent.
REQ-026 Port list SHALL be identical in both builds; when the macro is defined, s0/s1 remain present and unused.

Verification
REQ-027 Directed select, bits=16, all out_ready=1: send 0x1111/0x2222/0x3333/0x4444 with {s1,s0}=0,1,2,3 -> y0..y3 show these values one cycle after each accept; in_ready is constant 1.
REQ-028 Backpressure: out_ready[2]=0, send 0xAAAA then 0xBBBB to channel 2 -> 0xAAAA is held, in_ready=0 for the second word; raise out_ready[2] -> 0xBBBB is accepted in that same cycle and y2=0xBBBB next cycle, with no cycle where out_valid[2]=0.
REQ-029 Parallel drain: channel 0 stalled and full, stream 0x0005 to channel 3 -> channel 3 accepts every cycle and y0 is unchanged.
REQ-030 Reset mid-stream: channels 1 and 3 full, pulse rst for one cycle -> out_valid=0000, y1=y3=0x0000, and a word offered during rst is not accepted.
REQ-031 With DEMUX_ROUND_ROBIN_EN: s0=s1=1, send 5 words 0x0001 to 0x0005 -> they land on y0,y1,y2,y3,y0; a stall on channel 1 does not advance the pointer.
